// File: rtl/bitwise_logic_pipe_if.sv
// Request/result bundle for bitwise_logic_pipe: valid/ready request with two operands
// and an op code in; registered result, reduction flags and accept counter out.
interface bitwise_logic_pipe_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             red_and;
   logic             red_or;
   logic             red_xor;
   logic [CNT_W-1:0] op_count;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, y, red_and, red_or, red_xor, op_count
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, y, red_and, red_or, red_xor, op_count
   );
endinterface

// File: rtl/bitwise_logic_pipe.sv
// Single-stage bitwise ALU (AND/OR/XOR/NAND/NOR/XNOR/NOT/pass) with registered reduction flags.
// Latency 1; one-entry output register with skid-free ready: in_ready = !out_valid | out_ready.
module bitwise_logic_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   bitwise_logic_pipe_if.slave io
);
   logic             in_ready;
   logic             accept;
   logic [WIDTH-1:0] res;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             red_and_q, red_and_d;
   logic             red_or_q, red_or_d;
   logic             red_xor_q, red_xor_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;

   always_comb begin
      in_ready = ~out_valid_q | io.out_ready;
      accept   = io.in_valid & in_ready;

      res = io.a;
      case (io.op)
         3'b000:  res = io.a & io.b;
         3'b001:  res = io.a | io.b;
         3'b010:  res = io.a ^ io.b;
         3'b011:  res = ~(io.a & io.b);
         3'b100:  res = ~(io.a | io.b);
         3'b101:  res = ~(io.a ^ io.b);
         3'b110:  res = ~io.a;
         default: res = io.a;
      endcase

      out_valid_d = out_valid_q;
      y_d         = y_q;
      red_and_d   = red_and_q;
      red_or_d    = red_or_q;
      red_xor_d   = red_xor_q;
      op_count_d  = op_count_q;

      if (accept) begin
         out_valid_d = 1'b1;
         y_d         = res;
         // Flags come from the same value loaded into y so they can never disagree.
         red_and_d   = &res;
         red_or_d    = |res;
         red_xor_d   = ^res;
         op_count_d  = op_count_q + 1'b1;
      end else if (io.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         y_q         <= '0;
         red_and_q   <= 1'b0;
         red_or_q    <= 1'b0;
         red_xor_q   <= 1'b0;
         op_count_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         red_and_q   <= red_and_d;
         red_or_q    <= red_or_d;
         red_xor_q   <= red_xor_d;
         op_count_q  <= op_count_d;
      end
   end

   assign io.in_ready  = in_ready;
   assign io.out_valid = out_valid_q;
   assign io.y         = y_q;
   assign io.red_and   = red_and_q;
   assign io.red_or    = red_or_q;
   assign io.red_xor   = red_xor_q;
   assign io.op_count  = op_count_q;
endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Directed bench for bitwise_logic_pipe: main instance (WIDTH=8, CNT_W=16) plus a
// CNT_W=4 instance for counter wrap.
module tb_bitwise_logic_pipe;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   bitwise_logic_pipe_if #(.WIDTH(8), .CNT_W(16)) io ();
   bitwise_logic_pipe_if #(.WIDTH(8), .CNT_W(4))  w ();

   bitwise_logic_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io.slave)
   );

   bitwise_logic_pipe #(.WIDTH(8), .CNT_W(4)) u_wrap (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (w.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      io.in_valid = 1'b0;
      w.in_valid  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Sweep with a=CA, b=5C for op 0..7; every result happens to have even parity.
   logic [7:0] sweep_y [8];
   // Extra vectors: op, a, b, y, red_and, red_or, red_xor
   logic [2:0] ex_op  [6];
   logic [7:0] ex_a   [6];
   logic [7:0] ex_b   [6];
   logic [7:0] ex_y   [6];
   logic [2:0] ex_fl  [6];

   initial begin
      sweep_y = '{8'h48, 8'hDE, 8'h96, 8'hB7, 8'h21, 8'h69, 8'h35, 8'hCA};
      ex_op = '{3'd7,  3'd7,  3'd0,  3'd3,  3'd2,  3'd6};
      ex_a  = '{8'h01, 8'hFF, 8'hF0, 8'hF0, 8'h07, 8'hFE};
      ex_b  = '{8'h00, 8'h00, 8'h0F, 8'h0F, 8'h00, 8'h00};
      ex_y  = '{8'h01, 8'hFF, 8'h00, 8'hFF, 8'h07, 8'h01};
      ex_fl = '{3'b011, 3'b110, 3'b000, 3'b110, 3'b011, 3'b011};

      n_checks     = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      io.in_valid  = 1'b0;
      io.a         = '0;
      io.b         = '0;
      io.op        = '0;
      io.out_ready = 1'b0;
      w.in_valid   = 1'b0;
      w.a          = 8'h5A;
      w.b          = 8'hFF;
      w.op         = 3'd0;
      w.out_ready  = 1'b1;

      // In reset: outputs cleared, in_ready high even with out_ready low.
      #2;
      chk("rst_in_ready", 64'(io.in_ready), 64'd1);
      chk("rst_out_valid", 64'(io.out_valid), 64'd0);
      chk("rst_y", 64'(io.y), 64'h00);
      chk("rst_count", 64'(io.op_count), 64'd0);

      do_reset();
      #1;
      chk("post_rst_out_valid", 64'(io.out_valid), 64'd0);
      chk("post_rst_y", 64'(io.y), 64'h00);
      chk("post_rst_count", 64'(io.op_count), 64'd0);
      chk("post_rst_in_ready", 64'(io.in_ready), 64'd1);

      // Op sweep
      io.out_ready = 1'b1;
      io.in_valid  = 1'b1;
      io.a         = 8'hCA;
      io.b         = 8'h5C;
      for (int i = 0; i < 8; i++) begin
         io.op = 3'(i);
         @(posedge clk); #1;
         chk($sformatf("sweep_y_op%0d", i), 64'(io.y), 64'(sweep_y[i]));
         chk($sformatf("sweep_vld_op%0d", i), 64'(io.out_valid), 64'd1);
         chk($sformatf("sweep_xor_op%0d", i), 64'(io.red_xor), 64'd0);
      end
      for (int i = 0; i < 6; i++) begin
         io.op = ex_op[i];
         io.a  = ex_a[i];
         io.b  = ex_b[i];
         @(posedge clk); #1;
         chk($sformatf("ex_y_%0d", i), 64'(io.y), 64'(ex_y[i]));
         chk($sformatf("ex_flags_%0d", i), 64'({io.red_and, io.red_or, io.red_xor}), 64'(ex_fl[i]));
      end
      // Drain with no new request: valid drops, y holds.
      io.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("drain_vld", 64'(io.out_valid), 64'd0);
      chk("drain_y_hold", 64'(io.y), 64'h01);
      chk("sweep_count", 64'(io.op_count), 64'd14);

      // Backpressure
      do_reset();
      io.out_ready = 1'b0;
      io.in_valid  = 1'b1;
      io.a         = 8'hFF;
      io.b         = 8'h0F;
      io.op        = 3'd0;
      @(posedge clk); #1;
      chk("bp_y_first", 64'(io.y), 64'h0F);
      chk("bp_in_ready", 64'(io.in_ready), 64'd0);
      io.op = 3'd1;
      repeat (2) @(posedge clk);
      #1;
      chk("bp_y_held", 64'(io.y), 64'h0F);
      chk("bp_vld_held", 64'(io.out_valid), 64'd1);
      chk("bp_flags_held", 64'({io.red_and, io.red_or, io.red_xor}), 64'b010);
      chk("bp_count_held", 64'(io.op_count), 64'd1);
      io.out_ready = 1'b1;
      #1;
      chk("bp_in_ready_release", 64'(io.in_ready), 64'd1);
      @(posedge clk); #1;
      chk("bp_y_second", 64'(io.y), 64'hFF);
      chk("bp_vld_second", 64'(io.out_valid), 64'd1);
      io.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp_count_end", 64'(io.op_count), 64'd2);

      // Throughput: one result per cycle
      do_reset();
      io.out_ready = 1'b1;
      io.in_valid  = 1'b1;
      io.op        = 3'd2;
      io.b         = 8'h3C;
      for (int i = 0; i < 10; i++) begin
         io.a = 8'(i * 29 + 7);
         @(posedge clk); #1;
         chk($sformatf("tp_vld_%0d", i), 64'(io.out_valid), 64'd1);
         chk($sformatf("tp_y_%0d", i), 64'(io.y), 64'(8'(i * 29 + 7) ^ 8'h3C));
      end
      io.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("tp_count", 64'(io.op_count), 64'd10);

      // Counter wrap on CNT_W=4 instance
      do_reset();
      w.in_valid = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      chk("wrap_15", 64'(w.op_count), 64'd15);
      @(posedge clk); #1;
      chk("wrap_16", 64'(w.op_count), 64'd0);
      @(posedge clk); #1;
      w.in_valid = 1'b0;
      chk("wrap_17", 64'(w.op_count), 64'd1);
      @(posedge clk); #1;
      chk("wrap_idle", 64'(w.op_count), 64'd1);

      // Async reset mid-stall
      do_reset();
      io.out_ready = 1'b0;
      io.in_valid  = 1'b1;
      io.a         = 8'hA5;
      io.op        = 3'd7;
      @(posedge clk); #1;
      io.in_valid = 1'b0;
      chk("ar_pre_vld", 64'(io.out_valid), 64'd1);
      chk("ar_pre_y", 64'(io.y), 64'hA5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_vld", 64'(io.out_valid), 64'd0);
      chk("ar_y", 64'(io.y), 64'h00);
      chk("ar_flags", 64'({io.red_and, io.red_or, io.red_xor}), 64'b000);
      chk("ar_count", 64'(io.op_count), 64'd0);
      chk("ar_in_ready", 64'(io.in_ready), 64'd1);
      @(negedge clk);
      rst_n       = 1'b1;
      io.in_valid = 1'b1;
      io.a        = 8'h3C;
      #1;
      chk("ar_discarded", 64'(io.out_valid), 64'd0);
      @(posedge clk); #1;
      chk("ar_first_y", 64'(io.y), 64'h3C);
      chk("ar_first_count", 64'(io.op_count), 64'd1);
      io.in_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bitwise_logic_pipe.md
BITWISE_LOGIC_PIPE -- requirements
Module: bitwise_logic_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 1 to 64).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the accepted-operation counter.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock, rising-edge active.
REQ-004 Port rst_n SHALL be an input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port in_valid SHALL be an input, 1 bit: a, b and op carry a request.
REQ-006 Port in_ready SHALL be an output, 1 bit: the block can accept a request this cycle.
REQ-007 Port a SHALL be an input, WIDTH bits: operand A.
REQ-008 Port b SHALL be an input, WIDTH bits: operand B.
REQ-009 Port op SHALL be an input, 3 bits: operation select.
REQ-010 Port out_valid SHALL be an output, 1 bit: y and the reduction flags hold a result.
REQ-011 Port out_ready SHALL be an input, 1 bit: the downstream consumer takes the result.
REQ-012 Port y SHALL be an output, WIDTH bits: registered bitwise result.
REQ-013 Port red_and SHALL be an output, 1 bit: AND-reduction of y.
REQ-014 Port red_or SHALL be an output, 1 bit: OR-reduction of y.
REQ-015 Port red_xor SHALL be an output, 1 bit: XOR-reduction of y (parity).
REQ-016 Port op_count SHALL be an output, CNT_W bits: number of requests accepted since reset.

Function
REQ-017 Op encoding SHALL be: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT a, 111 pass a (b is ignored for 110 and 111).
REQ-018 All operations SHALL be bitwise per bit position, with no carry between bits and no width growth.
REQ-019 A request SHALL be accepted on a rising clk edge where in_valid and in_ready are both 1.
REQ-020 in_ready SHALL be combinational and SHALL equal (not out_valid) or out_ready.
REQ-021 On accept, y SHALL load op(a, b) computed from the values sampled on that edge, and out_valid SHALL be 1 from the next cycle (latency 1).
REQ-022 red_and, red_or and red_xor SHALL be registered together with y and SHALL always match the current y.
REQ-023 While out_valid is 1 and out_ready is 0, y, the reduction flags and out_valid SHALL hold stable, and no request SHALL be accepted.
REQ-024 On an edge with out_valid=1, out_ready=1 and no accept, out_valid SHALL go to 0; y SHALL keep its last value.
REQ-025 On an edge with a simultaneous drain and accept, the new result SHALL replace the old one and out_valid SHALL stay 1 (full throughput of one result per cycle).
REQ-026 op_count SHALL increment by 1 on each accept, SHALL wrap from 2^CNT_W-1 to 0, and SHALL NOT change on any other edge.
REQ-027 in_valid asserted while in_ready is 0 SHALL have no effect: no state change and no count increment.
REQ-028 The block SHALL contain no combinational path from a, b or op to any output.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for clk, force out_valid=0, y=0, red_and=0, red_or=0, red_xor=0 and op_count=0.
REQ-030 While rst_n=0, in_ready SHALL read 1 and accepts SHALL be suppressed.
REQ-031 Reset asserted mid-stall SHALL discard the pending result.
REQ-032 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-033 Post-reset check: with WIDTH=8, after reset out_valid=0, y=8'h00, op_count=0 and in_ready=1.
REQ-034 Op sweep: a=8'hCA, b=8'h5C, out_ready=1, op stepped 0 to 7 -> y = 48, DE, 96, B7, 21, 69, 35, CA one cycle after each op; red_xor shows the parity of each y.
REQ-035 Backpressure: out_ready=0, two back-to-back requests (AND then OR of FF, 0F) -> y=0F held and in_ready=0; the second request is accepted only after out_ready=1; op_count=2 at the end.
REQ-036 Throughput: 10 consecutive requests with out_ready=1 -> 10 results on 10 consecutive cycles, op_count=10.
REQ-037 Wrap: with CNT_W=4, 17 accepts -> op_count=1.
REQ-038 Async reset: drop rst_n between clk edges while out_valid=1 -> out_valid and y are 0 before the next edge, and op_count=0.
